// File: rtl/tangram_pkg.sv
// Shared types, initial piece placement and small arithmetic helpers for tangram_piece_ctrl.
package tangram_pkg;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [2:0]  rot;
  } piece_t;

  typedef enum logic [1:0] {StIdle, StPend, StApply} state_t;

  typedef struct packed {
    logic [2:0]         idx;
    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic               rot;
  } cmd_t;

  localparam int unsigned MOVE_UP = 0;
  localparam int unsigned MOVE_DN = 1;
  localparam int unsigned MOVE_LT = 2;
  localparam int unsigned MOVE_RT = 3;

  localparam logic [10:0] INIT_X [0:6] = '{11'd100, 11'd200, 11'd300, 11'd400,
                                           11'd500, 11'd600, 11'd700};
  localparam logic [10:0] INIT_Y [0:6] = '{11'd100, 11'd150, 11'd200, 11'd250,
                                           11'd300, 11'd350, 11'd400};
  localparam logic [2:0]  INIT_ROT [0:6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd6};

  function automatic piece_t init_piece(input int unsigned i);
    piece_t     p;
    logic [2:0] k;
    p = '0;
    k = 3'(i);
    if (i < 7) begin
      p.x   = INIT_X[k];
      p.y   = INIT_Y[k];
      p.rot = INIT_ROT[k];
    end
    return p;
  endfunction

  // Opposing buttons pressed together cancel on that axis.
  function automatic logic signed [11:0] axis_step(input logic neg, input logic pos,
                                                   input int unsigned step);
    logic signed [11:0] s;
    s = 12'(step);
    if (neg && !pos)      return -s;
    else if (pos && !neg) return s;
    else                  return 12'sd0;
  endfunction

  function automatic logic [10:0] clamp_add(input logic [10:0] cur, input logic signed [11:0] d,
                                            input int unsigned max);
    logic signed [11:0] sum;
    int                 s;
    sum = $signed({1'b0, cur}) + d;
    s   = int'(sum);
    if (s < 0)                 return 11'd0;
    else if (s > int'(max) - 1) return 11'(max - 1);
    else                       return 11'(s);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, registered press-edge pulse.
module btn_debounce
  import tangram_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 800000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    r_sync;
  logic          r_state;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // A change is accepted only after DB_CYCLES consecutive cycles differing from the held state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_state <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      if (r_sync[1] == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        r_state <= r_sync[1];
        r_press <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_state;
  assign o_press = r_press;

endmodule

// File: rtl/tangram_piece_ctrl.sv
// Tangram piece position/rotation owner; edits commit only on frame_start.
// Optional auto-repeat of held move buttons when AUTO_REPEAT_EN is defined.
module tangram_piece_ctrl
  import tangram_pkg::*;
#(
  parameter int unsigned NPIECE    = 7,
  parameter int unsigned DB_CYCLES = 800000,
  parameter int unsigned STEP      = 8,
  parameter int unsigned XMAX      = 800,
  parameter int unsigned YMAX      = 600,
  parameter int unsigned REP_DLY   = 20,
  parameter int unsigned REP_PER   = 4
) (
  input  logic                   i_clk_40m,
  input  logic                   i_clr_n,
  input  logic                   i_frame_start,
  input  logic [NPIECE-1:0]      i_select,
  input  logic                   i_rotate_btn,
  input  logic [3:0]             i_move_btn,
  output logic [NPIECE*11-1:0]   o_piece_x,
  output logic [NPIECE*11-1:0]   o_piece_y,
  output logic [NPIECE*3-1:0]    o_piece_rot,
  output logic [2:0]             o_active_idx,
  output logic                   o_active_vld,
  output logic                   o_busy
);

  logic [4:0] w_btn_raw;
  logic [4:0] w_lvl;
  logic [4:0] w_press;

  assign w_btn_raw = {i_move_btn, i_rotate_btn};

  for (genvar g = 0; g < 5; g++) begin : g_db
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .i_clk  (i_clk_40m),
      .i_rst_n(i_clr_n),
      .i_btn  (w_btn_raw[g]),
      .o_level(w_lvl[g]),
      .o_press(w_press[g])
    );
  end

  logic w_unused_rot_lvl;
  assign w_unused_rot_lvl = w_lvl[0];

  logic [NPIECE-1:0] r_sel_s0;
  logic [NPIECE-1:0] r_sel_s1;
  logic [2:0]        r_active_idx;
  logic              r_active_vld;
  logic [2:0]        w_idx;
  logic              w_vld;

  always_comb begin
    w_idx = '0;
    w_vld = 1'b0;
    for (int i = 0; i < NPIECE; i++) begin
      if (r_sel_s1[i] && !w_vld) begin
        w_idx = 3'(i);
        w_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk_40m or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_sel_s0     <= '0;
      r_sel_s1     <= '0;
      r_active_idx <= '0;
      r_active_vld <= 1'b0;
    end else begin
      r_sel_s0     <= i_select;
      r_sel_s1     <= r_sel_s0;
      r_active_idx <= w_idx;
      r_active_vld <= w_vld;
    end
  end

  logic [3:0] w_move_press;
  logic [3:0] w_move_lvl;
  logic       w_rot_press;
  logic       w_press_any;
  logic       w_rep;

  assign w_rot_press  = w_press[0];
  assign w_move_press = w_press[4:1];
  assign w_move_lvl   = w_lvl[4:1];
  assign w_press_any  = w_rot_press | (|w_move_press);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned DW = $clog2(REP_DLY + 1);
  localparam int unsigned PW = $clog2(REP_PER + 1);

  logic [DW-1:0] r_rep_dly;
  logic [PW-1:0] r_rep_per;
  logic          r_rep_armed;
  logic          r_rep;

  // Frame_starts are counted while any move button stays held; release restarts the delay.
  always_ff @(posedge i_clk_40m or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_rep_dly   <= '0;
      r_rep_per   <= '0;
      r_rep_armed <= 1'b0;
      r_rep       <= 1'b0;
    end else begin
      r_rep <= 1'b0;
      if (!(|w_move_lvl)) begin
        r_rep_dly   <= '0;
        r_rep_per   <= '0;
        r_rep_armed <= 1'b0;
      end else if (i_frame_start) begin
        if (!r_rep_armed) begin
          if (r_rep_dly == DW'(REP_DLY - 1)) begin
            r_rep_armed <= 1'b1;
            r_rep       <= 1'b1;
          end else begin
            r_rep_dly <= r_rep_dly + 1'b1;
          end
        end else if (r_rep_per == PW'(REP_PER - 1)) begin
          r_rep_per <= '0;
          r_rep     <= 1'b1;
        end else begin
          r_rep_per <= r_rep_per + 1'b1;
        end
      end
    end
  end

  assign w_rep = r_rep;
`else
  logic [31:0] w_unused_rep_cfg;
  assign w_unused_rep_cfg = REP_DLY ^ REP_PER;
  assign w_rep = 1'b0;
`endif

  logic [3:0] w_src;
  cmd_t       w_cmd;
  logic       w_cmd_vld;

  always_comb begin
    w_src     = w_press_any ? w_move_press : w_move_lvl;
    w_cmd     = '0;
    w_cmd.idx = r_active_idx;
    w_cmd.dx  = axis_step(w_src[MOVE_LT], w_src[MOVE_RT], STEP);
    w_cmd.dy  = axis_step(w_src[MOVE_UP], w_src[MOVE_DN], STEP);
    w_cmd.rot = w_rot_press;
    w_cmd_vld = r_active_vld & (w_press_any | w_rep);
  end

  state_t r_state;
  cmd_t   r_cmd;
  logic   r_busy;
  piece_t r_piece [NPIECE];
  piece_t w_cur;
  piece_t w_new;

  always_comb begin
    w_cur = '0;
    for (int i = 0; i < NPIECE; i++) begin
      if (r_cmd.idx == 3'(i)) w_cur = r_piece[i];
    end
    w_new     = '0;
    w_new.x   = clamp_add(w_cur.x, r_cmd.dx, XMAX);
    w_new.y   = clamp_add(w_cur.y, r_cmd.dy, YMAX);
    w_new.rot = w_cur.rot + {2'b00, r_cmd.rot};
  end

  always_ff @(posedge i_clk_40m or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state <= StIdle;
      r_cmd   <= '0;
      r_busy  <= 1'b0;
      for (int i = 0; i < NPIECE; i++) r_piece[i] <= init_piece(i);
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_cmd_vld) begin
            r_cmd   <= w_cmd;
            r_busy  <= 1'b1;
            r_state <= StPend;
          end
        end
        StPend: begin
          if (i_frame_start) r_state <= StApply;
        end
        StApply: begin
          for (int i = 0; i < NPIECE; i++) begin
            if (r_cmd.idx == 3'(i)) r_piece[i] <= w_new;
          end
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  for (genvar g = 0; g < NPIECE; g++) begin : g_out
    assign o_piece_x[11*g +: 11] = r_piece[g].x;
    assign o_piece_y[11*g +: 11] = r_piece[g].y;
    assign o_piece_rot[3*g +: 3] = r_piece[g].rot;
  end

  assign o_active_idx = r_active_idx;
  assign o_active_vld = r_active_vld;
  assign o_busy       = r_busy;

endmodule
